mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the pipelined RV32I core.
- Arbitrates between requests, sequences each access through an issue/wait/response FSM, and generates the stall_F / stall_M signals used by the pipeline registers.
- Only one access is in flight at a time.

Parameters:
- WIDTH, 32, data width of the memory and of both requester ports.
- ADDR_WIDTH, 32, byte address width.
- MEM_LATENCY, 2, number of cycles from mem_en to valid mem_rdata. Legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- if_req  in  1  fetch read request; level, held until if_valid.
- if_addr  in  ADDR_WIDTH  fetch address; stable while if_req is high.
- if_rdata  out  WIDTH  fetched instruction; valid when if_valid=1.
- if_valid  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request; level, held until dm_valid.
- dm_we  in  1  1 = store, 0 = load; stable while dm_req is high.
- dm_addr  in  ADDR_WIDTH  data address.
- dm_wdata  in  WIDTH  store data.
- dm_rdata  out  WIDTH  load data; valid when dm_valid=1.
- dm_valid  out  1  one-cycle completion pulse for data (loads and stores).
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  WIDTH  memory write data.
- mem_rdata  in  WIDTH  memory read data; valid MEM_LATENCY cycles after mem_en.
- stall_F  out  1  equals if_req && !if_valid (combinational).
- stall_M  out  1  equals dm_req && !dm_valid (combinational).

Behaviour:
- Interface fixed: one clock; reset is synchronous and active-high.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset values: state=IDLE, wait counter=0, last_grant=FETCH, all registered outputs 0 (if_valid, dm_valid, if_rdata, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata).
- IDLE:
  - No request: stay in IDLE.
  - Exactly one requester active: grant it.
  - Both active: grant the requester NOT in last_grant. Strict alternation on conflict; the first tie after reset goes to data.
  - On grant: latch owner, address, we and wdata (we=0 for fetch); update last_grant; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_en=1, mem_addr=latched address, mem_we=latched we, mem_wdata=latched wdata.
  - Load counter with MEM_LATENCY; go to WAIT.
  - Outside ISSUE, mem_en=0, mem_we=0, mem_addr=0 and mem_wdata=0.
- WAIT (MEM_LATENCY cycles):
  - Decrement the counter each cycle.
  - In the cycle the counter equals 1, capture mem_rdata into the owner's rdata register; go to RESP.
- RESP (1 cycle):
  - Owner's valid=1; the other requester's valid=0. rdata holds its value until the next capture for that port.
  - For stores, dm_valid still pulses and dm_rdata holds the mem_rdata sampled at capture (don't-care to consumers).
  - Go to IDLE. Requests are not sampled in RESP: the served requester's req is still high in this cycle and must not cause a re-grant.
- Timing: request first seen in IDLE at cycle t gives mem_en in t+1, capture in t+1+MEM_LATENCY, and valid in t+2+MEM_LATENCY. Back-to-back accesses cost MEM_LATENCY+3 cycles each.
- Requester protocol: after seeing valid, a requester either drops req or presents a new request in the following cycle. A req dropped before valid is a protocol violation; behaviour is unspecified.
- Address and data are latched at grant, so requester-side changes after grant have no effect on the access.
- Reset mid-operation (any state): return to IDLE next cycle and abort the in-flight access. No valid pulse is produced for it, and late mem_rdata is ignored.
- No address-range checks, misalignment handling or byte enables in this block (word accesses only).

Test Plan:
- Single fetch, MEM_LATENCY=2: if_req=1, if_addr=0x00000100 at cycle 0; memory returns 0xDEADBEEF in cycle 3 -> mem_en=1 only in cycle 1 with mem_addr=0x100; if_valid=1 only in cycle 4 with if_rdata=0xDEADBEEF; stall_F=1 in cycles 0–3 and 0 in cycle 4; dm_valid stays 0.
- Store: dm_req=1, dm_we=1, dm_addr=0x2000, dm_wdata=0x12345678 -> in cycle 1, mem_en=1, mem_we=1, mem_wdata=0x12345678; dm_valid pulses in cycle 4; mem_we=0 in all other cycles.
- Conflict after reset: if_req and dm_req both high from cycle 0 and held -> data granted first (mem_addr=dm_addr in cycle 1, dm_valid in cycle 4); fetch then granted (mem_en in cycle 6, if_valid in cycle 9).
- Sustained contention: both requesters re-request immediately after each valid for 6 accesses -> grant order D,F,D,F,D,F; each valid 5 cycles apart; never two valids in the same cycle.
- Reset mid-access: fetch issued, rst=1 in the first WAIT cycle -> no if_valid; state IDLE next cycle; a subsequent fetch to 0x104 completes normally with latency MEM_LATENCY+2.
- MEM_LATENCY=1 build: single load dm_addr=0x40, mem_rdata=0xCAFEF00D in cycle 2 -> dm_valid in cycle 3 with dm_rdata=0xCAFEF00D.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port fixed-latency memory between fetch and data requesters.
// Requests are arbitrated and each access runs IDLE -> ISSUE -> WAIT -> RESP, one at a time.
module mem_port_arbiter #(
  parameter int WIDTH       = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [WIDTH-1:0]      if_rdata,
  output logic                  if_valid,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [WIDTH-1:0]      dm_wdata,
  output logic [WIDTH-1:0]      dm_rdata,
  output logic                  dm_valid,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic                  stall_F,
  output logic                  stall_M
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  logic [1:0] state;
  logic [3:0] cnt;
  logic       owner;
  logic       last_grant;
  logic       pick_data;

  // On conflict the requester that did not win last time is served.
  assign pick_data = dm_req && (!if_req || (last_grant == OWN_FETCH));

  assign stall_F = if_req && !if_valid;
  assign stall_M = dm_req && !dm_valid;

  // The mem_* output registers, loaded at grant and cleared after ISSUE,
  // double as the latched address/we/wdata of the access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= OWN_FETCH;
      last_grant <= OWN_FETCH;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            owner      <= pick_data;
            last_grant <= pick_data;
            mem_en     <= 1'b1;
            mem_we     <= pick_data ? dm_we : 1'b0;
            mem_addr   <= pick_data ? dm_addr : if_addr;
            mem_wdata  <= pick_data ? dm_wdata : '0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= 4'(MEM_LATENCY);
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (owner == OWN_DATA) begin
              dm_rdata <= mem_rdata;
              dm_valid <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
